axi_lite_regif_responder: RTL and testbench

AXI-Lite responder (slave) front end for the systolic array accelerator. It terminates the PS-side AXI-Lite port and holds the CTRL/STATUS registers and the 36-word activation register file. It generates the one-cycle start pulse for the compute FSM and reads output words from the core's result memory through a 1-cycle-latency read port. It is the responding end of the host load/start/poll/readback register protocol.

---
 rtl/axi_lite_regif_responder_if.sv | 37 +++
 rtl/axi_lite_regif_responder.sv | 201 ++++++++++++++++++++
 tb/tb_axi_lite_regif_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_regif_responder_if.sv
// AXI-Lite bus bundle between the PS-side host (master) and the register front end (slave).
interface axi_lite_regif_responder_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_regif_responder.sv
// AXI-Lite register front end for the systolic array: CTRL/STATUS, activation
// register file, start pulse generation and result-memory readback.
module axi_lite_regif_responder #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 12,
    parameter int unsigned NUM_ACT            = 36,
    parameter int unsigned NUM_OUT_WORDS      = 64
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    axi_lite_regif_responder_if.slave      s_axi,
    output logic                           start_pulse,
    input  logic                           core_done,
    input  logic                           core_idle,
    input  logic [7:0]                     status_state,
    input  logic [3:0]                     status_kij,
    input  logic [5:0]                     act_raddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]  act_rdata,
    output logic [5:0]                     out_raddr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]  out_rdata
);
    localparam int unsigned DW          = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW          = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned STRB_W      = DW / 8;
    localparam int unsigned WORD_W      = AW - 2;
    localparam int unsigned IDX_W       = 6;
    localparam int unsigned CTRL_WORD   = 0;
    localparam int unsigned STATUS_WORD = 1;
    localparam int unsigned ACT_BASE    = 2;
    localparam int unsigned ACT_END     = ACT_BASE + NUM_ACT;
    localparam int unsigned OUT_BASE    = 64;
    localparam int unsigned OUT_END     = OUT_BASE + NUM_OUT_WORDS;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} rd_state_e;

    logic [DW-1:0]     act_q [NUM_ACT];
    logic              done_q;

    logic              aw_full_q, w_full_q, awready_q, wready_q, bvalid_q;
    logic [WORD_W-1:0] aw_word_q;
    logic [DW-1:0]     w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic [1:0]        bresp_q;

    logic              aw_hs_c, w_hs_c, b_hs_c, commit_c;
    logic              aw_full_n_c, w_full_n_c, bvalid_n_c;
    logic              wr_ctrl_c, wr_act_c, act_we_c, start_fire_c;
    logic [IDX_W-1:0]  act_widx_c;
    logic [1:0]        wr_resp_c;

    rd_state_e         rd_state_q, rd_state_n;
    logic              arready_q, rvalid_q, ar_hs_c, rd_load_c;
    logic [WORD_W-1:0] ar_word_q;
    logic [DW-1:0]     rdata_q, rd_data_c;
    logic [1:0]        rresp_q, rd_resp_c;
    logic [IDX_W-1:0]  rd_aidx_c;

    logic              unused_ok;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    // Write channel holders, commit decision and address decode of the held request
    always_comb begin
        aw_hs_c      = s_axi.awvalid && awready_q;
        w_hs_c       = s_axi.wvalid && wready_q;
        b_hs_c       = bvalid_q && s_axi.bready;
        commit_c     = aw_full_q && w_full_q && !bvalid_q;
        aw_full_n_c  = b_hs_c ? 1'b0 : (aw_full_q || aw_hs_c);
        w_full_n_c   = b_hs_c ? 1'b0 : (w_full_q || w_hs_c);
        bvalid_n_c   = commit_c || (bvalid_q && !s_axi.bready);
        wr_ctrl_c    = (aw_word_q == WORD_W'(CTRL_WORD));
        wr_act_c     = (aw_word_q >= WORD_W'(ACT_BASE)) && (aw_word_q < WORD_W'(ACT_END));
        act_widx_c   = IDX_W'(aw_word_q - WORD_W'(ACT_BASE));
        act_we_c     = commit_c && wr_act_c && core_idle;
        start_fire_c = commit_c && wr_ctrl_c && w_strb_q[0] && w_data_q[0] && core_idle;
        wr_resp_c    = RESP_SLVERR;
        if (wr_ctrl_c || (wr_act_c && core_idle)) begin
            wr_resp_c = RESP_OKAY;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            aw_word_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            start_pulse <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            aw_full_q   <= aw_full_n_c;
            w_full_q    <= w_full_n_c;
            bvalid_q    <= bvalid_n_c;
            awready_q   <= !aw_full_n_c && !bvalid_n_c;
            wready_q    <= !w_full_n_c && !bvalid_n_c;
            start_pulse <= start_fire_c;
            if (aw_hs_c) aw_word_q <= s_axi.awaddr[AW-1:2];
            if (w_hs_c) begin
                w_data_q <= s_axi.wdata;
                w_strb_q <= s_axi.wstrb;
            end
            if (commit_c) bresp_q <= wr_resp_c;
            // An accepted start beats a coincident core_done
            if (start_fire_c)   done_q <= 1'b0;
            else if (core_done) done_q <= 1'b1;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int unsigned i = 0; i < NUM_ACT; i++) act_q[i] <= '0;
        end else if (act_we_c) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (w_strb_q[b]) act_q[act_widx_c][8*b +: 8] <= w_data_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        act_rdata = '0;
        if (act_raddr < IDX_W'(NUM_ACT)) act_rdata = act_q[act_raddr];
    end

    // Read FSM: fixed two-cycle gap so the result memory port has settled
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) rd_state_q <= R_IDLE;
        else                rd_state_q <= rd_state_n;
    end

    always_comb begin
        rd_state_n = rd_state_q;
        rd_load_c  = 1'b0;
        ar_hs_c    = s_axi.arvalid && arready_q;
        case (rd_state_q)
            R_IDLE:  if (ar_hs_c) rd_state_n = R_ADDR;
            R_ADDR:  rd_state_n = R_DATA;
            R_DATA:  begin
                rd_state_n = R_RESP;
                rd_load_c  = 1'b1;
            end
            R_RESP:  if (s_axi.rready) rd_state_n = R_IDLE;
            default: rd_state_n = R_IDLE;
        endcase
    end

    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_SLVERR;
        rd_aidx_c = IDX_W'(ar_word_q - WORD_W'(ACT_BASE));
        if (ar_word_q == WORD_W'(CTRL_WORD)) begin
            rd_data_c = DW'({core_idle, done_q, 1'b0});
            rd_resp_c = RESP_OKAY;
        end else if (ar_word_q == WORD_W'(STATUS_WORD)) begin
            rd_data_c = DW'({status_kij, status_state});
            rd_resp_c = RESP_OKAY;
        end else if ((ar_word_q >= WORD_W'(ACT_BASE)) && (ar_word_q < WORD_W'(ACT_END))) begin
            rd_data_c = act_q[rd_aidx_c];
            rd_resp_c = RESP_OKAY;
        end else if ((ar_word_q >= WORD_W'(OUT_BASE)) && (ar_word_q < WORD_W'(OUT_END))) begin
            rd_data_c = out_rdata;
            rd_resp_c = RESP_OKAY;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            ar_word_q <= '0;
            out_raddr <= '0;
        end else begin
            arready_q <= (rd_state_n == R_IDLE);
            rvalid_q  <= (rd_state_n == R_RESP);
            if (ar_hs_c) begin
                ar_word_q <= s_axi.araddr[AW-1:2];
                out_raddr <= IDX_W'(s_axi.araddr[AW-1:2] - WORD_W'(OUT_BASE));
            end
            if (rd_load_c) begin
                rdata_q <= rd_data_c;
                rresp_q <= rd_resp_c;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_regif_responder.sv
// Bench for axi_lite_regif_responder: vector table through a response scoreboard,
// plus hand sequences for holder timing, start/done, read latency and reset.
module tb_axi_lite_regif_responder;
    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] SLV = 2'b10;

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        idle;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_pulse, core_done, core_idle;
    logic [7:0]  status_state;
    logic [3:0]  status_kij;
    logic [5:0]  act_raddr, out_raddr;
    logic [31:0] act_rdata, out_rdata;
    logic [31:0] mem_salt;
    int          total, bad, start_cnt;
    vec_t        vt[$];
    exp_t        sb_q[$];

    axi_lite_regif_responder_if s_axi ();

    axi_lite_regif_responder dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi         (s_axi),
        .start_pulse   (start_pulse),
        .core_done     (core_done),
        .core_idle     (core_idle),
        .status_state  (status_state),
        .status_kij    (status_kij),
        .act_raddr     (act_raddr),
        .act_rdata     (act_rdata),
        .out_raddr     (out_raddr),
        .out_rdata     (out_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] out_model(input logic [5:0] j);
        return {16'hC0DE, 2'b00, j, 2'b01, j};
    endfunction

    // Result memory: one-cycle read latency
    always @(posedge clk) out_rdata <= out_model(out_raddr) ^ mem_salt;
    always @(posedge clk) if (start_pulse) start_cnt <= start_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic check1(input string nm, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s timed out", nm);
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output bit ok);
        bit aw_done, w_done, got, awf, wf;
        aw_done = 0; w_done = 0; got = 0; resp = 2'b11;
        s_axi.awaddr = a; s_axi.wdata = d; s_axi.wstrb = s;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            awf = s_axi.awvalid && s_axi.awready;
            wf  = s_axi.wvalid && s_axi.wready;
            tick();
            if (awf) begin s_axi.awvalid = 1'b0; aw_done = 1; end
            if (wf)  begin s_axi.wvalid = 1'b0;  w_done = 1;  end
        end
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        s_axi.bready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (s_axi.bvalid) begin resp = s_axi.bresp; got = 1; end
            tick();
        end
        s_axi.bready = 1'b0;
        ok = aw_done && w_done && got;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] data,
                            output logic [1:0] resp, output bit ok);
        bit hs, got;
        hs = 0; got = 0; data = 'x; resp = 2'b11;
        s_axi.araddr = a; s_axi.arvalid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin
            if (s_axi.arready) hs = 1;
            tick();
        end
        s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b1;
        for (int i = 0; i < 20 && hs && !got; i++) begin
            if (s_axi.rvalid) begin data = s_axi.rdata; resp = s_axi.rresp; got = 1; end
            tick();
        end
        s_axi.rready = 1'b0;
        ok = hs && got;
    endtask

    // Reads push their expectation first, then compare against the popped entry
    task automatic sb_read(input string nm, input logic [11:0] a, input logic [31:0] ed, input logic [1:0] er);
        logic [31:0] d; logic [1:0] r; bit ok; exp_t e;
        sb_q.push_back('{ed, er});
        axi_read(a, d, r, ok);
        e = sb_q.pop_front();
        if (!ok) fail_now(nm);
        else begin
            check32({nm, "_data"}, d, e.data);
            check32({nm, "_resp"}, 32'(r), 32'(e.resp));
        end
    endtask

    task automatic sb_write(input string nm, input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] er);
        logic [1:0] r; bit ok; exp_t e;
        sb_q.push_back('{32'h0, er});
        axi_write(a, d, s, r, ok);
        e = sb_q.pop_front();
        if (!ok) fail_now(nm);
        else check32({nm, "_bresp"}, 32'(r), 32'(e.resp));
    endtask

    initial begin
        int base;
        logic [31:0] held;
        bit seen;
        total = 0; bad = 0; mem_salt = '0;
        rst_n = 1'b0; core_done = 1'b0; core_idle = 1'b1;
        status_state = 8'h5A; status_kij = 4'hC; act_raddr = '0;
        s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
        s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;

        vt.push_back('{1'b0, 12'h000, 32'h0,        4'h0, 1'b1, 32'h0000_0004, OK});
        vt.push_back('{1'b0, 12'h004, 32'h0,        4'h0, 1'b1, 32'h0000_0C5A, OK});
        vt.push_back('{1'b0, 12'h007, 32'h0,        4'h0, 1'b1, 32'h0000_0C5A, OK});
        vt.push_back('{1'b1, 12'h008, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0,         OK});
        vt.push_back('{1'b0, 12'h008, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF,  OK});
        vt.push_back('{1'b1, 12'h008, 32'h00001200, 4'h2, 1'b1, 32'h0,         OK});
        vt.push_back('{1'b0, 12'h008, 32'h0,        4'h0, 1'b1, 32'hDEAD12EF,  OK});
        vt.push_back('{1'b1, 12'h094, 32'h12345678, 4'hF, 1'b1, 32'h0,         OK});
        vt.push_back('{1'b0, 12'h094, 32'h0,        4'h0, 1'b1, 32'h12345678,  OK});
        vt.push_back('{1'b0, 12'h098, 32'h0,        4'h0, 1'b1, 32'h0,         SLV});
        vt.push_back('{1'b1, 12'h004, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,         SLV});
        vt.push_back('{1'b0, 12'h004, 32'h0,        4'h0, 1'b1, 32'h0000_0C5A, OK});
        vt.push_back('{1'b1, 12'h200, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,         SLV});
        vt.push_back('{1'b1, 12'h100, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,         SLV});
        vt.push_back('{1'b1, 12'h00C, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,         SLV});
        vt.push_back('{1'b0, 12'h00C, 32'h0,        4'h0, 1'b1, 32'h0,         OK});
        vt.push_back('{1'b0, 12'h008, 32'h0,        4'h0, 1'b0, 32'hDEAD12EF,  OK});
        vt.push_back('{1'b1, 12'h000, 32'h1,        4'hF, 1'b0, 32'h0,         OK});
        vt.push_back('{1'b0, 12'h000, 32'h0,        4'h0, 1'b0, 32'h0,         OK});
        vt.push_back('{1'b0, 12'h104, 32'h0,        4'h0, 1'b1, out_model(6'd1),  OK});
        vt.push_back('{1'b0, 12'h1FC, 32'h0,        4'h0, 1'b1, out_model(6'd63), OK});
        vt.push_back('{1'b0, 12'h0FC, 32'h0,        4'h0, 1'b1, 32'h0,         SLV});
        vt.push_back('{1'b1, 12'h00C, 32'h000000AA, 4'h1, 1'b1, 32'h0,         OK});
        vt.push_back('{1'b0, 12'h00C, 32'h0,        4'h0, 1'b1, 32'h0000_00AA, OK});
        vt.push_back('{1'b1, 12'h000, 32'h0,        4'hF, 1'b1, 32'h0,         OK});
        vt.push_back('{1'b0, 12'h200, 32'h0,        4'h0, 1'b1, 32'h0,         SLV});

        // Reset values, then readiness after release
        tick(); tick();
        check1("rst_awready", s_axi.awready, 1'b0);
        check1("rst_arready", s_axi.arready, 1'b0);
        check1("rst_bvalid", s_axi.bvalid, 1'b0);
        check1("rst_rvalid", s_axi.rvalid, 1'b0);
        check32("rst_rdata", s_axi.rdata, 32'h0);
        check32("rst_out_raddr", 32'(out_raddr), 32'h0);
        rst_n = 1'b1;
        tick();
        check1("rel_awready", s_axi.awready, 1'b1);
        check1("rel_wready", s_axi.wready, 1'b1);
        check1("rel_arready", s_axi.arready, 1'b1);
        check1("rel_start", start_pulse, 1'b0);

        base = start_cnt;
        foreach (vt[i]) begin
            core_idle = vt[i].idle;
            if (vt[i].wr) sb_write($sformatf("vec%0d", i), vt[i].addr, vt[i].data, vt[i].strb, vt[i].exp_resp);
            else          sb_read($sformatf("vec%0d", i), vt[i].addr, vt[i].exp_data, vt[i].exp_resp);
        end
        core_idle = 1'b1;
        tick();
        check32("table_no_start", 32'(start_cnt - base), 32'h0);

        act_raddr = 6'd0;  #1 check32("act_rd0", act_rdata, 32'hDEAD12EF);
        act_raddr = 6'd35; #1 check32("act_rd35", act_rdata, 32'h12345678);
        act_raddr = 6'd36; #1 check32("act_rd36", act_rdata, 32'h0);
        act_raddr = 6'd63; #1 check32("act_rd63", act_rdata, 32'h0);
        tick();

        // AW three cycles ahead of W, then a stalled B
        s_axi.awaddr = 12'h010; s_axi.awvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check1($sformatf("awearly_nob%0d", k), s_axi.bvalid, 1'b0);
            tick();
        end
        s_axi.wdata = 32'hCAFE0001; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
        check1("awearly_wready", s_axi.wready, 1'b1);
        tick();
        s_axi.wvalid = 1'b0;
        check1("awearly_w_edge_nob", s_axi.bvalid, 1'b0);
        tick();
        check1("awearly_commit_b", s_axi.bvalid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check1($sformatf("bhold_bvalid%0d", k), s_axi.bvalid, 1'b1);
            check1($sformatf("bhold_awready%0d", k), s_axi.awready, 1'b0);
        end
        check32("bhold_bresp", 32'(s_axi.bresp), 32'(OK));
        s_axi.bready = 1'b1;
        tick();
        s_axi.bready = 1'b0;
        check1("bhs_bvalid", s_axi.bvalid, 1'b0);
        check1("bhs_awready", s_axi.awready, 1'b1);
        check1("bhs_wready", s_axi.wready, 1'b1);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (s_axi.bvalid) seen = 1;
        end
        check1("single_bvalid", seen, 1'b0);
        sb_read("awearly_rb", 12'h010, 32'hCAFE0001, OK);

        // Start pulse and done handling
        base = start_cnt;
        sb_write("start1", 12'h000, 32'h1, 4'hF, OK);
        tick(); tick();
        check32("start1_cnt", 32'(start_cnt - base), 32'h1);
        core_done = 1'b1; tick(); core_done = 1'b0;
        sb_read("done_set", 12'h000, 32'h6, OK);
        base = start_cnt;
        sb_write("start2", 12'h000, 32'h1, 4'hF, OK);
        tick(); tick();
        check32("start2_cnt", 32'(start_cnt - base), 32'h1);
        sb_read("done_clr", 12'h000, 32'h4, OK);
        core_done = 1'b1; tick(); core_done = 1'b0;
        sb_read("done_set2", 12'h000, 32'h6, OK);
        base = start_cnt;
        s_axi.awaddr = 12'h000; s_axi.wdata = 32'h1; s_axi.wstrb = 4'hF;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check1("same_cyc_bvalid", s_axi.bvalid, 1'b1);
        s_axi.bready = 1'b1; tick(); s_axi.bready = 1'b0;
        tick();
        check32("same_cyc_cnt", 32'(start_cnt - base), 32'h1);
        sb_read("same_cyc_done", 12'h000, 32'h4, OK);

        // Output region read latency and R stall
        s_axi.araddr = 12'h104; s_axi.arvalid = 1'b1;
        check1("rd_arready", s_axi.arready, 1'b1);
        tick();
        s_axi.arvalid = 1'b0;
        check32("rd_out_raddr", 32'(out_raddr), 32'h1);
        check1("rd_n0_rvalid", s_axi.rvalid, 1'b0);
        tick();
        check1("rd_n1_rvalid", s_axi.rvalid, 1'b0);
        tick();
        check1("rd_n2_rvalid", s_axi.rvalid, 1'b1);
        check32("rd_n2_rdata", s_axi.rdata, out_model(6'd1));
        check32("rd_n2_rresp", 32'(s_axi.rresp), 32'(OK));
        held = out_model(6'd1);
        mem_salt = 32'h0F0F_0F0F;
        for (int k = 0; k < 4; k++) begin
            tick();
            check1($sformatf("rhold_rvalid%0d", k), s_axi.rvalid, 1'b1);
            check32($sformatf("rhold_rdata%0d", k), s_axi.rdata, held);
            check1($sformatf("rhold_arready%0d", k), s_axi.arready, 1'b0);
        end
        s_axi.rready = 1'b1; tick(); s_axi.rready = 1'b0;
        mem_salt = '0;
        check1("rhs_rvalid", s_axi.rvalid, 1'b0);
        check1("rhs_arready", s_axi.arready, 1'b1);

        // Reset while a write response is pending
        s_axi.awaddr = 12'h008; s_axi.wdata = 32'h11111111; s_axi.wstrb = 4'hF;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        tick();
        check1("pre_rst_bvalid", s_axi.bvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check1("midrst_bvalid", s_axi.bvalid, 1'b0);
        check1("midrst_awready", s_axi.awready, 1'b0);
        act_raddr = 6'd0;
        #1 check32("midrst_act0", act_rdata, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        check1("postrst_awready", s_axi.awready, 1'b1);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (s_axi.bvalid || s_axi.rvalid) seen = 1;
            tick();
        end
        check1("postrst_no_resp", seen, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
